// File: rtl/multi_wr_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// multi_wr_scheduler_pkg
//   Shared types and helpers for the multi-WR instruction/write-data scheduler:
//   - sched_state_e  : scheduler FSM states (IDLE / GATHER / EMIT)
//   - DEF_CMD_WR_CODE: default type encoding of a WR command
//   - slot_offset()  : bit offset of a write-data slot inside the slot vector
// ---------------------------------------------------------------------------
package multi_wr_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_EMIT   = 2'd2
  } sched_state_e;

  localparam int DEF_CMD_WR_CODE = 4;

  // Offset of slot idx when slots of width w are packed LSB-first.
  function automatic int slot_offset(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/multi_wr_scheduler_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with show-ahead read (dout is the head entry while
//   !empty). Ready is derived by the user as !full; a push into a full FIFO
//   is ignored even if a pop happens in the same cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers/level only)
//   push, din  : write strobe and data
//   pop, dout  : read strobe and head data
//   full, empty: status flags
//   level      : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset: stale entries are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/multi_wr_scheduler.sv
// ---------------------------------------------------------------------------
// multi_wr_scheduler
//   Buffers host instruction and write-data streams in independent FIFOs,
//   pairs each WR command of an instruction with its own write-data beat
//   (ascending slot order) and emits one merged word under ready/valid.
//
// Ports:
//   clk, rst                         : clock, async active-high reset
//   S_AXIS_INSTR_TDATA/TVALID/TREADY : instruction stream (TREADY = !full)
//   S_AXIS_WDATA_TDATA/TVALID/TREADY : write-data stream  (TREADY = !full)
//   M_TDATA/M_TVALID/M_TREADY        : merged output; [INSTR_WIDTH-1:0] is the
//                                      instruction, slot i sits at
//                                      [INSTR_WIDTH+i*WDATA_WIDTH +: WDATA_WIDTH]
//   instr_level, wdata_level         : FIFO occupancies
//   wait_cycles                      : stall counter
//
// Build option: define SCHED_PERF_CNT_EN to enable the saturating
// wait_cycles counter (GATHER with empty wdata FIFO, or EMIT with
// M_TREADY low). Without it wait_cycles is tied to zero.
// ---------------------------------------------------------------------------
module multi_wr_scheduler
  import multi_wr_scheduler_pkg::*;
#(
  parameter int NUM_CMDS    = 4,
  parameter int CMD_WIDTH   = 32,
  parameter int CMD_TYPE_W  = 3,
  parameter int CMD_WR_CODE = DEF_CMD_WR_CODE,
  parameter int WDATA_WIDTH = 512,
  parameter int IFIFO_DEPTH = 4,
  parameter int WFIFO_DEPTH = 8,
  localparam int INSTR_WIDTH = NUM_CMDS * CMD_WIDTH,
  localparam int OUT_WIDTH   = INSTR_WIDTH + NUM_CMDS * WDATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INSTR_WIDTH-1:0]         S_AXIS_INSTR_TDATA,
  input  logic                           S_AXIS_INSTR_TVALID,
  output logic                           S_AXIS_INSTR_TREADY,
  input  logic [WDATA_WIDTH-1:0]         S_AXIS_WDATA_TDATA,
  input  logic                           S_AXIS_WDATA_TVALID,
  output logic                           S_AXIS_WDATA_TREADY,
  output logic [OUT_WIDTH-1:0]           M_TDATA,
  output logic                           M_TVALID,
  input  logic                           M_TREADY,
  output logic [$clog2(IFIFO_DEPTH):0]   instr_level,
  output logic [$clog2(WFIFO_DEPTH):0]   wdata_level,
  output logic [31:0]                    wait_cycles
);

  localparam int SLOTS_W = NUM_CMDS * WDATA_WIDTH;

  // FIFO interfaces
  logic                   if_full, if_empty, if_pop;
  logic [INSTR_WIDTH-1:0] if_dout;
  logic                   wf_full, wf_empty, wf_pop;
  logic [WDATA_WIDTH-1:0] wf_dout;

  // Work register and FSM state
  sched_state_e           state_q, state_d;
  logic [INSTR_WIDTH-1:0] work_q, work_d;
  logic [SLOTS_W-1:0]     slots_q, slots_d;
  logic [NUM_CMDS-1:0]    mask_q, mask_d;

  logic [NUM_CMDS-1:0]    head_mask;
  logic [NUM_CMDS-1:0]    lowest;
  logic                   load;

  sync_fifo #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (IFIFO_DEPTH)
  ) u_instr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (S_AXIS_INSTR_TVALID),
    .din   (S_AXIS_INSTR_TDATA),
    .pop   (if_pop),
    .dout  (if_dout),
    .full  (if_full),
    .empty (if_empty),
    .level (instr_level)
  );

  sync_fifo #(
    .WIDTH (WDATA_WIDTH),
    .DEPTH (WFIFO_DEPTH)
  ) u_wdata_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (S_AXIS_WDATA_TVALID),
    .din   (S_AXIS_WDATA_TDATA),
    .pop   (wf_pop),
    .dout  (wf_dout),
    .full  (wf_full),
    .empty (wf_empty),
    .level (wdata_level)
  );

  assign S_AXIS_INSTR_TREADY = !if_full;
  assign S_AXIS_WDATA_TREADY = !wf_full;
  assign M_TVALID            = (state_q == ST_EMIT);
  assign M_TDATA             = {slots_q, work_q};

  // WR slots of the instruction at the head of the instruction FIFO.
  always_comb begin
    head_mask = '0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      head_mask[i] = (if_dout[i*CMD_WIDTH +: CMD_TYPE_W] == CMD_TYPE_W'(CMD_WR_CODE));
    end
  end

  // Isolate the lowest pending WR slot; beats fill slots in ascending order.
  assign lowest = mask_q & (~mask_q + NUM_CMDS'(1));

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    slots_d = slots_q;
    mask_d  = mask_q;
    if_pop  = 1'b0;
    wf_pop  = 1'b0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!if_empty) load = 1'b1;
      end
      ST_GATHER: begin
        if (!wf_empty) begin
          wf_pop = 1'b1;
          for (int i = 0; i < NUM_CMDS; i++) begin
            if (lowest[i]) slots_d[slot_offset(i, WDATA_WIDTH) +: WDATA_WIDTH] = wf_dout;
          end
          mask_d = mask_q & ~lowest;
          if (mask_d == '0) state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        // Reload in the acceptance cycle so back-to-back words have no bubble.
        if (M_TREADY) begin
          if (!if_empty) load = 1'b1;
          else           state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      if_pop  = 1'b1;
      work_d  = if_dout;
      slots_d = '0;
      mask_d  = head_mask;
      state_d = (head_mask != '0) ? ST_GATHER : ST_EMIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      slots_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      slots_q <= slots_d;
      mask_q  <= mask_d;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] wait_q, wait_d;
  logic        stalled;

  assign stalled = ((state_q == ST_GATHER) && wf_empty) ||
                   ((state_q == ST_EMIT) && !M_TREADY);

  always_comb begin
    wait_d = wait_q;
    if (stalled && (wait_q != 32'hFFFF_FFFF)) wait_d = wait_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end

  assign wait_cycles = wait_q;
`else
  assign wait_cycles = '0;
`endif

endmodule

// File: tb/tb_multi_wr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_multi_wr_scheduler
//   Directed bench for multi_wr_scheduler with default parameters. Stimulus
//   pushes the expected merged word into a queue when it issues an
//   instruction; a negedge monitor pops and compares on every accepted
//   output word. Timing/level checks are made #1 after the active edge.
// ---------------------------------------------------------------------------
module tb_multi_wr_scheduler;

  localparam int IW = 128;
  localparam int WW = 512;
  localparam int OW = IW + 4 * WW;

`ifdef SCHED_PERF_CNT_EN
  localparam logic [31:0] EXP_TRICKLE_WAIT = 32'd16;
`else
  localparam logic [31:0] EXP_TRICKLE_WAIT = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] instr_tdata;
  logic          instr_tvalid;
  logic          instr_tready;
  logic [WW-1:0] wdata_tdata;
  logic          wdata_tvalid;
  logic          wdata_tready;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [2:0]    instr_level;
  logic [3:0]    wdata_level;
  logic [31:0]   wait_cycles;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [OW-1:0] exp_q [$];

  multi_wr_scheduler dut (
    .clk                 (clk),
    .rst                 (rst),
    .S_AXIS_INSTR_TDATA  (instr_tdata),
    .S_AXIS_INSTR_TVALID (instr_tvalid),
    .S_AXIS_INSTR_TREADY (instr_tready),
    .S_AXIS_WDATA_TDATA  (wdata_tdata),
    .S_AXIS_WDATA_TVALID (wdata_tvalid),
    .S_AXIS_WDATA_TREADY (wdata_tready),
    .M_TDATA             (m_tdata),
    .M_TVALID            (m_tvalid),
    .M_TREADY            (m_tready),
    .instr_level         (instr_level),
    .wdata_level         (wdata_level),
    .wait_cycles         (wait_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] beat(input logic [31:0] n);
    return {16{n}};
  endfunction

  function automatic logic [OW-1:0] merged(input logic [IW-1:0] ins, input logic [WW-1:0] s0,
                                           input logic [WW-1:0] s1, input logic [WW-1:0] s2,
                                           input logic [WW-1:0] s3);
    return {s3, s2, s1, s0, ins};
  endfunction

  // Instruction with no WR commands (every type field = 1).
  function automatic logic [IW-1:0] nowr(input logic [23:0] k);
    return {4{k, 8'h01}};
  endfunction

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_output: got instr %0h expected no output", m_tdata[IW-1:0]);
      end else begin
        logic [OW-1:0] e;
        e = exp_q.pop_front();
        check("out_instr", {384'b0, m_tdata[IW-1:0]}, {384'b0, e[IW-1:0]});
        for (int i = 0; i < 4; i++)
          check($sformatf("out_slot%0d", i), m_tdata[IW + i*WW +: WW], e[IW + i*WW +: WW]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_instr(input logic [IW-1:0] d);
    instr_tdata  = d;
    instr_tvalid = 1'b1;
    tick();
    instr_tvalid = 1'b0;
  endtask

  task automatic push_wdata(input logic [WW-1:0] d);
    wdata_tdata  = d;
    wdata_tvalid = 1'b1;
    tick();
    wdata_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
    check(name, WW'(exp_q.size()), '0);
  endtask

  logic [IW-1:0] ins;
  logic [IW-1:0] ins2;

  initial begin
    rst          = 1'b1;
    instr_tdata  = '0;
    instr_tvalid = 1'b0;
    wdata_tdata  = '0;
    wdata_tvalid = 1'b0;
    m_tready     = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Reset state
    check("rst_m_tvalid", WW'(m_tvalid), WW'(0));
    check("rst_m_tdata_instr", {384'b0, m_tdata[IW-1:0]}, '0);
    check("rst_m_tdata_slot0", m_tdata[IW +: WW], '0);
    check("rst_instr_level", WW'(instr_level), WW'(0));
    check("rst_wdata_level", WW'(wdata_level), WW'(0));
    check("rst_instr_tready", WW'(instr_tready), WW'(1));
    check("rst_wdata_tready", WW'(wdata_tready), WW'(1));
    check("rst_wait_cycles", WW'(wait_cycles), WW'(0));

    // Four WRs, write data trickled one beat every 5 cycles
    ins = {32'h3333_0004, 32'h2222_0004, 32'h1111_0004, 32'h0000_0004};
    exp_q.push_back(merged(ins, beat(32'hD000_0000), beat(32'hD000_0001),
                           beat(32'hD000_0002), beat(32'hD000_0003)));
    push_instr(ins);
    for (int b = 0; b < 4; b++) begin
      repeat (4) tick();
      push_wdata(beat(32'hD000_0000 + b));
      if (b == 1) check("trickle_stalled_valid", WW'(m_tvalid), WW'(0));
    end
    drain("trickle_drained");
    tick();
    check("trickle_wait_cycles", WW'(wait_cycles), WW'(EXP_TRICKLE_WAIT));

    // No-WR instruction: valid one cycle after accept, all slots zero
    ins = {32'h4000_0003, 32'h3000_0002, 32'h2000_0001, 32'h1000_0000};
    exp_q.push_back(merged(ins, '0, '0, '0, '0));
    push_instr(ins);
    check("nowr_valid_edge0", WW'(m_tvalid), WW'(0));
    tick();
    check("nowr_valid_edge1", WW'(m_tvalid), WW'(1));
    check("nowr_wdata_level", WW'(wdata_level), WW'(0));
    drain("nowr_drained");

    // WR at slots 1 and 3, write data buffered ahead of the instruction
    push_wdata(beat(32'hAAAA_0001));
    push_wdata(beat(32'hBBBB_0002));
    check("pre_wdata_level", WW'(wdata_level), WW'(2));
    ins = {32'h0000_0D34, 32'h0000_0C25, 32'h0000_0B14, 32'h0000_0A01};
    exp_q.push_back(merged(ins, '0, beat(32'hAAAA_0001), '0, beat(32'hBBBB_0002)));
    push_instr(ins);
    tick();
    tick();
    check("wr13_valid_edge2", WW'(m_tvalid), WW'(0));
    tick();
    check("wr13_valid_edge3", WW'(m_tvalid), WW'(1));
    drain("wr13_drained");
    check("wr13_wdata_level", WW'(wdata_level), WW'(0));

    // Backpressure: hold M_TREADY low while filling the instruction FIFO
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(merged(nowr(24'h100 + k), '0, '0, '0, '0));
      push_instr(nowr(24'h100 + k));
    end
    check("bp_instr_level", WW'(instr_level), WW'(4));
    check("bp_instr_tready", WW'(instr_tready), WW'(0));
    for (int c = 0; c < 6; c++) begin
      check("bp_valid_held", WW'(m_tvalid), WW'(1));
      check("bp_tdata_stable", {384'b0, m_tdata[IW-1:0]}, {384'b0, nowr(24'h100)});
      tick();
    end
    m_tready = 1'b1;
    check("bp_release_valid", WW'(m_tvalid), WW'(1));
    for (int c = 0; c < 4; c++) begin
      tick();
      check("bp_stream_valid", WW'(m_tvalid), WW'(1));
    end
    tick();
    check("bp_stream_end", WW'(m_tvalid), WW'(0));
    drain("bp_drained");

    // Eight beats with no instruction, then two all-WR instructions
    for (int b = 0; b < 8; b++) push_wdata(beat(32'hE000_0000 + b));
    check("wfull_level", WW'(wdata_level), WW'(8));
    check("wfull_tready", WW'(wdata_tready), WW'(0));
    ins  = {32'h5555_0004, 32'h5555_1004, 32'h5555_2004, 32'h5555_3004};
    ins2 = {32'h6666_0004, 32'h6666_1004, 32'h6666_2004, 32'h6666_3004};
    exp_q.push_back(merged(ins, beat(32'hE000_0000), beat(32'hE000_0001),
                           beat(32'hE000_0002), beat(32'hE000_0003)));
    exp_q.push_back(merged(ins2, beat(32'hE000_0004), beat(32'hE000_0005),
                           beat(32'hE000_0006), beat(32'hE000_0007)));
    push_instr(ins);
    push_instr(ins2);
    drain("wfull_drained");
    check("wfull_level_after", WW'(wdata_level), WW'(0));

    // Asynchronous reset while stalled in GATHER
    push_instr({32'h7777_0004, 32'h7777_1004, 32'h7777_2004, 32'h7777_3004});
    push_instr(nowr(24'h200));
    tick();
    check("prerst_instr_level", WW'(instr_level), WW'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_m_tvalid", WW'(m_tvalid), WW'(0));
    check("arst_instr_level", WW'(instr_level), WW'(0));
    check("arst_wdata_level", WW'(wdata_level), WW'(0));
    check("arst_m_tdata_instr", {384'b0, m_tdata[IW-1:0]}, '0);
    tick();
    rst = 1'b0;
    tick();
    ins = nowr(24'h300);
    exp_q.push_back(merged(ins, '0, '0, '0, '0));
    push_instr(ins);
    tick();
    check("postrst_valid", WW'(m_tvalid), WW'(1));
    drain("postrst_drained");

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
